// File: rtl/alu_op_sequencer_pkg.sv
// Shared types for the ALU operand sequencer.
// State encodings double as the board LED pattern.
package alu_op_sequencer_pkg;

  typedef enum logic [1:0] {
    S_A    = 2'b00,
    S_B    = 2'b01,
    S_EXEC = 2'b10,
    S_SHOW = 2'b11
  } state_e;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Operand/result bundle between the sequencer and the ALU.
// Master drives operands, slave returns the result.
interface alu_op_sequencer_if;
  logic [7:0] op_a;
  logic [7:0] op_b;
  logic       op_sel;
  logic [7:0] alu_result;
  logic       alu_flag;

  modport master (
    output op_a, op_b, op_sel,
    input  alu_result, alu_flag
  );

  modport slave (
    input  op_a, op_b, op_sel,
    output alu_result, alu_flag
  );
endinterface

// File: rtl/alu_op_sequencer_btn_debounce.sv
// Pushbutton synchronizer, stability filter and press pulse.
// Pulse fires once per debounced rising level.
module btn_debounce
  import alu_op_sequencer_pkg::*;
#(
  parameter int DEB_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic pulse_o
);

  localparam int CW = cnt_w(DEB_CYCLES);

  logic          s1_q;
  logic          s2_q;
  logic          lvl_q;
  logic          pulse_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      lvl_q   <= 1'b0;
      pulse_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      s1_q    <= btn_i;
      s2_q    <= s1_q;
      pulse_q <= 1'b0;
      if (s2_q == lvl_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(DEB_CYCLES - 1)) begin
        lvl_q   <= s2_q;
        pulse_q <= s2_q;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/alu_op_sequencer.sv
// Operand entry / execute controller for the add-sub ALU
// and the BCD display selection.
module alu_op_sequencer
  import alu_op_sequencer_pkg::*;
#(
  parameter int DEB_CYCLES   = 500000,
  parameter int BLINK_CYCLES = 12500000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 btn_next,
  input  logic                 btn_clear,
  input  logic [7:0]           sw_data,
  input  logic                 sw_op,
  alu_op_sequencer_if.master   alu,
  output logic [7:0]           res_raw,
  output logic                 res_flag,
  output logic                 res_valid,
  output logic                 disp_sel,
  output logic                 blink,
  output logic [1:0]           state_led
);

  localparam int BW = cnt_w(BLINK_CYCLES);

  logic nxt_p;
  logic clr_p;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_next (
    .clk     (clk),
    .reset   (reset),
    .btn_i   (btn_next),
    .pulse_o (nxt_p)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_clear (
    .clk     (clk),
    .reset   (reset),
    .btn_i   (btn_clear),
    .pulse_o (clr_p)
  );

  state_e        state_q;
  logic [7:0]    op_a_q;
  logic [7:0]    op_b_q;
  logic          op_sel_q;
  logic [7:0]    res_raw_q;
  logic          res_flag_q;
  logic          res_valid_q;
  logic          disp_sel_q;
  logic          blink_q;
  logic [BW-1:0] bcnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_A;
      op_a_q      <= '0;
      op_b_q      <= '0;
      op_sel_q    <= 1'b0;
      res_raw_q   <= '0;
      res_flag_q  <= 1'b0;
      res_valid_q <= 1'b0;
      disp_sel_q  <= 1'b0;
      blink_q     <= 1'b1;
      bcnt_q      <= '0;
    end else if (clr_p) begin
      state_q     <= S_A;
      op_a_q      <= '0;
      op_b_q      <= '0;
      op_sel_q    <= 1'b0;
      res_raw_q   <= '0;
      res_flag_q  <= 1'b0;
      res_valid_q <= 1'b0;
      disp_sel_q  <= 1'b0;
      blink_q     <= 1'b1;
      bcnt_q      <= '0;
    end else begin
      unique case (state_q)
        S_A, S_B: begin
          if (nxt_p) begin
            blink_q <= 1'b1;
            bcnt_q  <= '0;
            if (state_q == S_A) begin
              op_a_q  <= sw_data;
              state_q <= S_B;
            end else begin
              op_b_q   <= sw_data;
              op_sel_q <= sw_op;
              state_q  <= S_EXEC;
            end
          end else if (bcnt_q == BW'(BLINK_CYCLES - 1)) begin
            bcnt_q  <= '0;
            blink_q <= ~blink_q;
          end else begin
            bcnt_q <= bcnt_q + 1'b1;
          end
        end
        S_EXEC: begin
          // ALU has had one full cycle on the new operands
          res_raw_q   <= alu.alu_result;
          res_flag_q  <= alu.alu_flag;
          res_valid_q <= 1'b1;
          disp_sel_q  <= 1'b1;
          state_q     <= S_SHOW;
        end
        S_SHOW: begin
          if (nxt_p) begin
            res_valid_q <= 1'b0;
            disp_sel_q  <= 1'b0;
            blink_q     <= 1'b1;
            bcnt_q      <= '0;
            state_q     <= S_A;
          end
        end
        default: state_q <= S_A;
      endcase
    end
  end

  assign alu.op_a   = op_a_q;
  assign alu.op_b   = op_b_q;
  assign alu.op_sel = op_sel_q;
  assign res_raw    = res_raw_q;
  assign res_flag   = res_flag_q;
  assign res_valid  = res_valid_q;
  assign disp_sel   = disp_sel_q;
  assign blink      = blink_q;
  assign state_led  = state_q;

endmodule
